// File: rtl/usb_crc_pkg.sv
// Shared constants and state type for the serial USB CRC engine.
package usb_crc_pkg;

   localparam logic [4:0]  CRC5_POLY      = 5'h05;
   localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } crc_state_t;

endpackage

// File: rtl/crc_lfsr_step.sv
// Single-bit CRC remainder step. The TX-side generator reuses it.
// Bits arrive LSB first on the wire, and each one enters at the top of the register.
module crc_lfsr_step #(
   parameter int               CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY  = 16'h8005
) (
   input  logic [CRC_W-1:0] i_rem,
   input  logic             i_bit,
   output logic [CRC_W-1:0] o_rem_next
);

   logic w_fb;

   // Shift left, then fold in the polynomial when the feedback bit is set.
   always_comb begin
      w_fb       = i_rem[CRC_W-1] ^ i_bit;
      o_rem_next = {i_rem[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
   end

endmodule

// File: rtl/usb_crc_engine.sv
// Serial USB CRC engine covering CRC5 tokens and CRC16 data packets.
//
// state | meaning
// IDLE  | cleared, no bits absorbed yet
// RUN   | absorbing packet bits
// DONE  | verdict held until clear or reset
module usb_crc_engine
   import usb_crc_pkg::*;
#(
   parameter int               CRC_W    = 16,
   parameter logic [CRC_W-1:0] POLY     = CRC_W'(CRC16_POLY),
   parameter logic [CRC_W-1:0] INIT     = '1,
   parameter logic [CRC_W-1:0] RESIDUAL = CRC_W'(CRC16_RESIDUAL),
   parameter int               CNT_W    = 11
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             bit_valid,
   input  logic             data_bit,
   input  logic             check,
   output logic [CRC_W-1:0] crc_out,
   output logic             check_done,
   output logic             crc_ok,
   output logic             short_err,
   output logic [CNT_W-1:0] bit_count
);

   localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(CRC_W);

   crc_state_t       r_state;
   crc_state_t       w_state_next;
   logic [CRC_W-1:0] r_rem;
   logic [CNT_W-1:0] r_count;
   logic             r_ok;
   logic             r_short;

   logic [CRC_W-1:0] w_rem_step;
   logic [CRC_W-1:0] w_rem_next;
   logic [CNT_W-1:0] w_count_next;
   logic             w_absorb;
   logic             w_enter_done;

   crc_lfsr_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_step (
      .i_rem      (r_rem),
      .i_bit      (data_bit),
      .o_rem_next (w_rem_step)
   );

   // A coincident bit is absorbed before the check, so the verdict sees the post-update remainder and count.
   always_comb begin
      w_absorb     = bit_valid && (r_state != DONE);
      w_rem_next   = w_absorb ? w_rem_step : r_rem;
      w_count_next = (w_absorb && (r_count != '1)) ? r_count + CNT_W'(1) : r_count;
      w_enter_done = check && (r_state != DONE) && !clear;
   end

   // Next-state logic. clear wins over every other input.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (check)
               w_state_next = DONE;
            else if (bit_valid)
               w_state_next = RUN;
         end
         RUN: begin
            if (check)
               w_state_next = DONE;
         end
         DONE:    w_state_next = DONE;
         default: w_state_next = IDLE;
      endcase
      if (clear)
         w_state_next = IDLE;
   end

   // State, remainder, counter and verdict registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
         r_rem   <= INIT;
         r_count <= '0;
         r_ok    <= 1'b0;
         r_short <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (clear) begin
            r_rem   <= INIT;
            r_count <= '0;
            r_ok    <= 1'b0;
            r_short <= 1'b0;
         end else begin
            r_rem   <= w_rem_next;
            r_count <= w_count_next;
            if (w_enter_done) begin
               r_ok    <= (w_rem_next == RESIDUAL) && (w_count_next >= MIN_BITS);
               r_short <= (w_count_next < MIN_BITS);
            end
         end
      end
   end

   assign crc_out    = ~r_rem;
   assign check_done = (r_state == DONE);
   assign crc_ok     = r_ok;
   assign short_err  = r_short;
   assign bit_count  = r_count;

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine: CRC16 and CRC5 instances share one stimulus bus.
module tb_usb_crc_engine;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        clear;
   logic        bit_valid;
   logic        data_bit;
   logic        check;

   logic [15:0] c16_crc;
   logic        c16_done, c16_ok, c16_short;
   logic [10:0] c16_cnt;
   logic [4:0]  c5_crc;
   logic        c5_done, c5_ok, c5_short;
   logic [10:0] c5_cnt;

   int total = 0;
   int bad   = 0;

   usb_crc_engine u_crc16 (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear),
      .bit_valid  (bit_valid),
      .data_bit   (data_bit),
      .check      (check),
      .crc_out    (c16_crc),
      .check_done (c16_done),
      .crc_ok     (c16_ok),
      .short_err  (c16_short),
      .bit_count  (c16_cnt)
   );

   usb_crc_engine #(
      .CRC_W    (5),
      .POLY     (5'h05),
      .INIT     (5'h1F),
      .RESIDUAL (5'h0C)
   ) u_crc5 (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear),
      .bit_valid  (bit_valid),
      .data_bit   (data_bit),
      .check      (check),
      .crc_out    (c5_crc),
      .check_done (c5_done),
      .crc_ok     (c5_ok),
      .short_err  (c5_short),
      .bit_count  (c5_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle of stimulus; outputs are settled 1 time unit after the edge.
   task automatic drive(input logic v, input logic b, input logic c, input logic clr);
      @(negedge clk);
      bit_valid = v;
      data_bit  = b;
      check     = c;
      clear     = clr;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      data_bit  = 1'b0;
      check     = 1'b0;
      clear     = 1'b0;
   endtask

   task automatic send_bits(input int n, input logic b);
      for (int i = 0; i < n; i++)
         drive(1'b1, b, 1'b0, 1'b0);
   endtask

   // CRC5 of SETUP addr 0 endp 0 is crc_out 5'h08 (5'h02 when read in wire order), sent MSB first.
   logic [4:0] tok_crc;

   initial begin
      n_rst     = 1'b0;
      clear     = 1'b0;
      bit_valid = 1'b0;
      data_bit  = 1'b0;
      check     = 1'b0;
      tok_crc   = 5'h08;
      #12;
      chk("rst_crc16_out", c16_crc, 32'h0);
      chk("rst_crc5_out", c5_crc, 32'h0);
      chk("rst_done", c16_done, 32'h0);
      chk("rst_ok", c16_ok, 32'h0);
      chk("rst_short", c16_short, 32'h0);
      chk("rst_count", c16_cnt, 32'h0);
      #10 n_rst = 1'b1;

      // zero-length DATA0: 16 zero CRC bits leave the residual 800D
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(16, 1'b0);
      chk("c16_zero_crc_out", c16_crc, 32'h7FF2);
      chk("c16_done_before", c16_done, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c16_zero_done", c16_done, 32'h1);
      chk("c16_zero_ok", c16_ok, 32'h1);
      chk("c16_zero_short", c16_short, 32'h0);
      chk("c16_zero_count", c16_cnt, 32'd16);

      // SETUP token CRC5
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(11, 1'b0);
      chk("c5_tok_crc_out", c5_crc, 32'h08);
      for (int i = 4; i >= 0; i--)
         drive(1'b1, tok_crc[i], 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c5_tok_ok", c5_ok, 32'h1);
      chk("c5_tok_count", c5_cnt, 32'd16);
      chk("c5_tok_resid_out", c5_crc, 32'h13);
      send_bits(3, 1'b1);
      chk("c5_done_hold_count", c5_cnt, 32'd16);
      chk("c5_done_hold_crc", c5_crc, 32'h13);
      chk("c5_done_hold_done", c5_done, 32'h1);

      // single flipped bit in the CRC16 field
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++)
         drive(1'b1, (i == 5), 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c16_flip_done", c16_done, 32'h1);
      chk("c16_flip_ok", c16_ok, 32'h0);
      chk("c16_flip_short", c16_short, 32'h0);

      // short packet, then a bare check from IDLE
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c5_short_ok", c5_ok, 32'h0);
      chk("c5_short_err", c5_short, 32'h1);
      chk("c5_short_count", c5_cnt, 32'd3);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c5_bare_done", c5_done, 32'h1);
      chk("c5_bare_short", c5_short, 32'h1);
      chk("c5_bare_ok", c5_ok, 32'h0);
      chk("c5_bare_count", c5_cnt, 32'd0);

      // check coincident with the final CRC bit
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(11, 1'b0);
      for (int i = 4; i >= 1; i--)
         drive(1'b1, tok_crc[i], 1'b0, 1'b0);
      drive(1'b1, tok_crc[0], 1'b1, 1'b0);
      chk("c5_coinc_done", c5_done, 32'h1);
      chk("c5_coinc_ok", c5_ok, 32'h1);
      chk("c5_coinc_short", c5_short, 32'h0);
      chk("c5_coinc_count", c5_cnt, 32'd16);

      // clear beats a coincident bit mid-packet
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(5, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk("clr_crc_out", c16_crc, 32'h0);
      chk("clr_count", c16_cnt, 32'd0);
      chk("clr_done", c16_done, 32'h0);

      // asynchronous reset while in DONE
      send_bits(2, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("arst_pre_done", c16_done, 32'h1);
      #1 n_rst = 1'b0;
      #1;
      chk("arst_done", c16_done, 32'h0);
      chk("arst_count", c16_cnt, 32'd0);
      chk("arst_short", c16_short, 32'h0);
      #1 n_rst = 1'b1;

      // bit counter saturates rather than wrapping
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(2050, 1'b0);
      chk("sat_count", c16_cnt, 32'd2047);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
